// File: rtl/lfsr_checker.sv
// Receive-side checker for an XNOR LFSR word stream: hunts for a seed, verifies
// LOCK_CNT predictions, then flywheels and counts mismatches while locked.
module lfsr_checker #(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic                o_Sync_Loss,
  output logic [CNT_W-1:0]    o_Err_Count
);

  localparam int unsigned MRUN_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BRUN_W = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [31:0] tap(input int unsigned k);
    return 32'(1) << (k - 32'd1);
  endfunction

  // Maximal-length XNOR tap sets, 1-indexed bit k maps to w[k-1]
  function automatic logic [31:0] tap_mask(input int unsigned n);
    logic [31:0] m;
    case (n)
      3:       m = tap(3)  | tap(2);
      4:       m = tap(4)  | tap(3);
      5:       m = tap(5)  | tap(3);
      6:       m = tap(6)  | tap(5);
      7:       m = tap(7)  | tap(6);
      8:       m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:       m = tap(9)  | tap(5);
      10:      m = tap(10) | tap(7);
      11:      m = tap(11) | tap(9);
      12:      m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13:      m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14:      m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15:      m = tap(15) | tap(14);
      16:      m = tap(16) | tap(15) | tap(13) | tap(4);
      17:      m = tap(17) | tap(14);
      18:      m = tap(18) | tap(11);
      19:      m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20:      m = tap(20) | tap(17);
      21:      m = tap(21) | tap(19);
      22:      m = tap(22) | tap(21);
      23:      m = tap(23) | tap(18);
      24:      m = tap(24) | tap(23) | tap(22) | tap(17);
      25:      m = tap(25) | tap(22);
      26:      m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27:      m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28:      m = tap(28) | tap(25);
      29:      m = tap(29) | tap(27);
      30:      m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31:      m = tap(31) | tap(28);
      32:      m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TAPS_W   = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS     = TAPS_W[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

  // Even tap count, so the XNOR chain reduces to an inverted parity
  function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] w);
    return {w[NUM_BITS-2:0], ~(^(w & TAPS))};
  endfunction

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] expect_q, expect_d;
  logic [MRUN_W-1:0]   mrun_q, mrun_d;
  logic [BRUN_W-1:0]   brun_q, brun_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                loss_q, loss_d;
  logic                locked_q, locked_d;

  logic match;
  logic seed_ok;
  logic lock_hit;
  logic loss_hit;

  assign match    = (i_Data == expect_q);
  assign seed_ok  = (i_Data != ALL_ONES);
  assign lock_hit = ((mrun_q + MRUN_W'(1)) == MRUN_W'(LOCK_CNT));
  assign loss_hit = ((brun_q + BRUN_W'(1)) == BRUN_W'(LOSS_CNT));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_Valid) begin
      case (state_q)
        HUNT: begin
          if (seed_ok) state_d = VERIFY;
        end
        VERIFY: begin
          if (match) begin
            if (lock_hit) state_d = LOCKED;
          end else if (!seed_ok) begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (!match && loss_hit) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    expect_d = expect_q;
    mrun_d   = mrun_q;
    brun_d   = brun_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    loss_d   = 1'b0;
    if (i_Valid) begin
      case (state_q)
        HUNT: begin
          if (seed_ok) begin
            expect_d = lfsr_next(i_Data);
            mrun_d   = '0;
          end
        end
        VERIFY: begin
          if (match || seed_ok) expect_d = lfsr_next(i_Data);
          if (match) mrun_d = lock_hit ? '0 : (mrun_q + MRUN_W'(1));
          else       mrun_d = '0;
          brun_d = '0;
        end
        LOCKED: begin
          // Flywheel: never re-seed from data while locked
          expect_d = lfsr_next(expect_q);
          if (match) begin
            brun_d = '0;
          end else begin
            err_d  = 1'b1;
            loss_d = loss_hit;
            brun_d = loss_hit ? '0 : (brun_q + BRUN_W'(1));
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (i_Clear_Count) cnt_d = '0;
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      expect_q <= '0;
      mrun_q   <= '0;
      brun_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      loss_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      expect_q <= expect_d;
      mrun_q   <= mrun_d;
      brun_q   <= brun_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      loss_q   <= loss_d;
      locked_q <= locked_d;
    end
  end

  assign o_Locked    = locked_q;
  assign o_Error     = err_q;
  assign o_Sync_Loss = loss_q;
  assign o_Err_Count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default and CNT_W=2/LOSS_CNT=16) share
// stimulus; directed scenarios plus a random stream checked against a model.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       clr;
  logic [7:0] data;

  logic        a_locked, a_err, a_loss;
  logic [15:0] a_cnt;
  logic        b_locked, b_err, b_loss;
  logic [1:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sw;

  always #5 clk = ~clk;

  lfsr_checker #(.NUM_BITS(8), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .i_Data(data), .i_Clear_Count(clr),
    .o_Locked(a_locked), .o_Error(a_err), .o_Sync_Loss(a_loss), .o_Err_Count(a_cnt)
  );

  lfsr_checker #(.NUM_BITS(8), .LOCK_CNT(4), .LOSS_CNT(16), .CNT_W(2)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .i_Data(data), .i_Clear_Count(clr),
    .o_Locked(b_locked), .o_Error(b_err), .o_Sync_Loss(b_loss), .o_Err_Count(b_cnt)
  );

  // Reference model: mode 0=hunt, 1=verify, 2=locked; index 0 -> dut_a, 1 -> dut_b
  localparam int LOCKN = 4;
  int         loss_n[2]  = '{3, 16};
  int         cnt_max[2] = '{65535, 3};
  int         m_mode[2];
  logic [7:0] m_exp[2];
  int         m_mrun[2];
  int         m_brun[2];
  int         m_cnt[2];
  bit         m_err[2];
  bit         m_loss[2];

  // Next word: shift left, feed back 1 when taps 8,6,5,4 hold an even number of ones
  function automatic logic [7:0] nxt(input logic [7:0] w);
    int ones;
    ones = int'(w[7]) + int'(w[5]) + int'(w[4]) + int'(w[3]);
    return 8'({w, 1'b0}) | 8'(ones % 2 == 0);
  endfunction

  task automatic model_step(input int i);
    m_err[i]  = 1'b0;
    m_loss[i] = 1'b0;
    if (rst) begin
      m_mode[i] = 0; m_exp[i] = 8'h00; m_mrun[i] = 0; m_brun[i] = 0; m_cnt[i] = 0;
      return;
    end
    if (valid) begin
      if (m_mode[i] == 0) begin
        if (data != 8'hFF) begin m_exp[i] = nxt(data); m_mrun[i] = 0; m_mode[i] = 1; end
      end else if (m_mode[i] == 1) begin
        if (data == m_exp[i]) begin
          m_exp[i] = nxt(data);
          m_mrun[i]++;
          if (m_mrun[i] == LOCKN) begin m_mode[i] = 2; m_brun[i] = 0; end
        end else if (data != 8'hFF) begin
          m_exp[i] = nxt(data); m_mrun[i] = 0;
        end else begin
          m_mode[i] = 0;
        end
      end else begin
        if (data == m_exp[i]) m_brun[i] = 0;
        else begin
          m_err[i] = 1'b1;
          if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
          m_brun[i]++;
          if (m_brun[i] == loss_n[i]) begin m_mode[i] = 0; m_loss[i] = 1'b1; end
        end
        m_exp[i] = nxt(m_exp[i]);
      end
    end
    if (clr) m_cnt[i] = 0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit c);
    valid = v; data = d; clr = c;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h5A, 1'b0);
    rst = 1'b0;
    n_cmp++;
    if ({a_locked, a_err, a_loss, a_cnt} !== 19'd0) begin
      n_bad++; $display("FAIL reset_a: got lck/err/loss/cnt=%b%b%b/%0d want 0", a_locked, a_err, a_loss, a_cnt);
    end
    n_cmp++;
    if ({b_locked, b_err, b_loss, b_cnt} !== 5'd0) begin
      n_bad++; $display("FAIL reset_b: got lck/err/loss/cnt=%b%b%b/%0d want 0", b_locked, b_err, b_loss, b_cnt);
    end
  endtask

  task automatic test_lock();
    logic [7:0] seq [5] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      n_cmp++;
      if (a_locked !== (i == 4)) begin
        n_bad++; $display("FAIL lock_word%0d: got locked=%b want %b", i, a_locked, (i == 4));
      end
    end
    sw = 8'h1E;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, sw, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({a_locked, a_err, b_err} !== 3'b100) begin
        n_bad++; $display("FAIL lock_stream%0d: got lck/err_a/err_b=%b%b%b want 100", i, a_locked, a_err, b_err);
      end
    end
  endtask

  task automatic test_single_error();
    cycle(1'b1, sw ^ 8'h01, 1'b0);
    sw = nxt(sw);
    n_cmp++;
    if ({a_err, a_locked, a_loss} !== 3'b110 || a_cnt !== 16'd1 || b_cnt !== 2'd1) begin
      n_bad++; $display("FAIL single_err: got err/lck/loss=%b%b%b cnt_a=%0d cnt_b=%0d want 110 1 1",
                        a_err, a_locked, a_loss, a_cnt, b_cnt);
    end
    cycle(1'b1, sw, 1'b0);
    sw = nxt(sw);
    n_cmp++;
    if ({a_err, a_locked} !== 2'b01 || a_cnt !== 16'd1) begin
      n_bad++; $display("FAIL single_err_after: got err/lck=%b%b cnt=%0d want 01 1", a_err, a_locked, a_cnt);
    end
  endtask

  task automatic test_sync_loss();
    cycle(1'b1, sw, 1'b1);
    sw = nxt(sw);
    n_cmp++;
    if (a_cnt !== 16'd0 || b_cnt !== 2'd0) begin
      n_bad++; $display("FAIL clear: got cnt_a=%0d cnt_b=%0d want 0 0", a_cnt, b_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, sw ^ 8'h01, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({a_err, a_loss, a_locked} !== {1'b1, k == 2, k != 2} || a_cnt !== 16'(k + 1)) begin
        n_bad++; $display("FAIL burst%0d: got err/loss/lck=%b%b%b cnt=%0d want 1%b%b %0d",
                          k, a_err, a_loss, a_locked, a_cnt, (k == 2), (k != 2), k + 1);
      end
      n_cmp++;
      if ({b_err, b_loss, b_locked} !== 3'b101 || b_cnt !== 2'(k + 1)) begin
        n_bad++; $display("FAIL burst_b%0d: got err/loss/lck=%b%b%b cnt=%0d want 101 %0d",
                          k, b_err, b_loss, b_locked, b_cnt, k + 1);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, sw, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({a_locked, a_err, a_loss} !== {k == 4, 2'b00} || a_cnt !== 16'd3) begin
        n_bad++; $display("FAIL relock%0d: got lck/err/loss=%b%b%b cnt=%0d want %b00 3",
                          k, a_locked, a_err, a_loss, a_cnt, (k == 4));
      end
    end
  endtask

  task automatic test_hunt_ff();
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'hFF, 1'b0);
      n_cmp++;
      if ({a_locked, a_err, a_loss, b_err} !== 4'b0000) begin
        n_bad++; $display("FAIL hunt_ff%0d: got lck/err/loss/err_b=%b%b%b%b want 0000", k, a_locked, a_err, a_loss, b_err);
      end
    end
    sw = 8'h00;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, sw, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({a_locked, b_locked} !== {2{k == 4}}) begin
        n_bad++; $display("FAIL hunt_lock%0d: got lck_a/lck_b=%b%b want %b", k, a_locked, b_locked, (k == 4));
      end
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, sw ^ 8'h10, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({b_err, b_locked} !== 2'b11 || b_cnt !== 2'((k < 3) ? k + 1 : 3) || a_cnt !== 16'(k + 1)) begin
        n_bad++; $display("FAIL sat%0d: got err_b/lck_b=%b%b cnt_b=%0d cnt_a=%0d want 11 %0d %0d",
                          k, b_err, b_locked, b_cnt, a_cnt, (k < 3) ? k + 1 : 3, k + 1);
      end
      cycle(1'b1, sw, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({b_err, a_err, a_locked} !== 3'b001) begin
        n_bad++; $display("FAIL sat_gap%0d: got err_b/err_a/lck_a=%b%b%b want 001", k, b_err, a_err, a_locked);
      end
    end
    cycle(1'b1, sw ^ 8'h01, 1'b1);
    sw = nxt(sw);
    n_cmp++;
    if ({b_err, a_err} !== 2'b11 || b_cnt !== 2'd0 || a_cnt !== 16'd0) begin
      n_bad++; $display("FAIL clear_vs_err: got err_b/err_a=%b%b cnt_b=%0d cnt_a=%0d want 11 0 0",
                        b_err, a_err, b_cnt, a_cnt);
    end
  endtask

  task automatic test_gaps();
    cycle(1'b1, sw ^ 8'h02, 1'b0);
    sw = nxt(sw);
    n_cmp++;
    if (a_cnt !== 16'd1 || a_err !== 1'b1) begin
      n_bad++; $display("FAIL gap_pre: got cnt=%0d err=%b want 1 1", a_cnt, a_err);
    end
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < 2; g++) begin
        cycle(1'b0, 8'($urandom), 1'b0);
        n_cmp++;
        if ({a_locked, a_err, a_loss, b_err} !== 4'b1000 || a_cnt !== 16'd1) begin
          n_bad++; $display("FAIL gap_idle%0d: got lck/err/loss/err_b=%b%b%b%b cnt=%0d want 1000 1",
                            k, a_locked, a_err, a_loss, b_err, a_cnt);
        end
      end
      cycle(1'b1, sw, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if ({a_locked, a_err} !== 2'b10) begin
        n_bad++; $display("FAIL gap_word%0d: got lck/err=%b%b want 10", k, a_locked, a_err);
      end
    end
    rst = 1'b1;
    cycle(1'b1, sw ^ 8'h01, 1'b0);
    rst = 1'b0;
    sw = nxt(sw);
    n_cmp++;
    if ({a_locked, a_err, a_loss} !== 3'b000 || a_cnt !== 16'd0 || {b_locked, b_err} !== 2'b00) begin
      n_bad++; $display("FAIL mid_reset: got lck/err/loss=%b%b%b cnt=%0d lck_b/err_b=%b%b want 000 0 00",
                        a_locked, a_err, a_loss, a_cnt, b_locked, b_err);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, sw, 1'b0);
      sw = nxt(sw);
      n_cmp++;
      if (a_locked !== (k == 4)) begin
        n_bad++; $display("FAIL post_reset_lock%0d: got lck=%b want %b", k, a_locked, (k == 4));
      end
    end
  endtask

  task automatic test_random();
    int burst = 0;
    bit v, c, bad;
    logic [7:0] d;
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    sw = 8'($urandom_range(0, 254));
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      v   = ($urandom_range(0, 9) != 0);
      c   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) sw = 8'($urandom_range(0, 254));
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 4);
      bad = v && (burst > 0);
      if (bad) burst--;
      if (!v)                              d = 8'($urandom);
      else if ($urandom_range(0, 99) == 0) d = 8'hFF;
      else if (bad)                        d = sw ^ 8'($urandom_range(1, 255));
      else                                 d = sw;
      cycle(v, d, c);
      rst = 1'b0;
      if (v) sw = nxt(sw);
      n_cmp++;
      if ({a_locked, a_err, a_loss} !== {m_mode[0] == 2, m_err[0], m_loss[0]} || a_cnt !== 16'(m_cnt[0])) begin
        n_bad++; $display("FAIL rand_a@%0d: got lck/err/loss=%b%b%b cnt=%0d want %b%b%b %0d", n,
                          a_locked, a_err, a_loss, a_cnt, (m_mode[0] == 2), m_err[0], m_loss[0], m_cnt[0]);
      end
      n_cmp++;
      if ({b_locked, b_err, b_loss} !== {m_mode[1] == 2, m_err[1], m_loss[1]} || b_cnt !== 2'(m_cnt[1])) begin
        n_bad++; $display("FAIL rand_b@%0d: got lck/err/loss=%b%b%b cnt=%0d want %b%b%b %0d", n,
                          b_locked, b_err, b_loss, b_cnt, (m_mode[1] == 2), m_err[1], m_loss[1], m_cnt[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; clr = 1'b0; data = 8'h00; sw = 8'h00;
    test_reset();
    test_lock();
    test_single_error();
    test_sync_loss();
    test_hunt_ff();
    test_saturate();
    test_gaps();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
